// File: rtl/timebase_controller_if.sv
// Control and status bundle for timebase_controller.
// The master drives configuration and commands; the slave (the timer) returns the timing outputs.
interface timebase_controller_if #(
    parameter int unsigned WIDTH = 32
);
    logic             cfg_we;
    logic [WIDTH-1:0] cfg_period;
    logic             start;
    logic             stop;
    logic             pause;
    logic             oneshot;
    logic             tick;
    logic             clkout;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] remaining;

    modport master (
        output cfg_we, cfg_period, start, stop, pause, oneshot,
        input  tick, clkout, busy, done, remaining
    );

    modport slave (
        input  cfg_we, cfg_period, start, stop, pause, oneshot,
        output tick, clkout, busy, done, remaining
    );
endinterface

// File: rtl/timebase_controller.sv
// Programmable period timer with periodic/one-shot modes, pause and abort.
// Produces a one-cycle tick per expiry, a toggling clkout and a registered remaining count.
module timebase_controller #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned DEFAULT_PERIOD = 25000000
) (
    input logic                  clk,
    input logic                  reset,
    timebase_controller_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] period_q;
    logic             mode_q;  // 1 = one-shot
    logic             tick_q;
    logic             clkout_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] remaining_q;

    logic             idle_like;
    logic             expiry;
    logic [WIDTH-1:0] period_nxt;

    always_comb begin
        idle_like  = (state_q == StIdle) || (state_q == StDone);
        expiry     = (state_q == StRun) && (count_q == period_q - WIDTH'(1));
        period_nxt = period_q;
        // Period is only reprogrammable while no count is in progress; zero is rejected.
        if (idle_like && bus.cfg_we && (bus.cfg_period != '0)) begin
            period_nxt = bus.cfg_period;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            count_q     <= '0;
            period_q    <= WIDTH'(DEFAULT_PERIOD);
            mode_q      <= 1'b0;
            tick_q      <= 1'b0;
            clkout_q    <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            remaining_q <= '0;
        end else begin
            period_q <= period_nxt;
            tick_q   <= 1'b0;
            if (bus.stop) begin
                state_q     <= StIdle;
                count_q     <= '0;
                busy_q      <= 1'b0;
                done_q      <= 1'b0;
                remaining_q <= '0;
            end else begin
                unique case (state_q)
                    StRun: begin
                        if (expiry) begin
                            tick_q   <= 1'b1;
                            clkout_q <= ~clkout_q;
                            count_q  <= '0;
                            if (mode_q) begin
                                state_q     <= StDone;
                                busy_q      <= 1'b0;
                                done_q      <= 1'b1;
                                remaining_q <= '0;
                            end else begin
                                // A pause coinciding with expiry parks at count 0.
                                state_q     <= bus.pause ? StPause : StRun;
                                remaining_q <= period_q;
                            end
                        end else if (bus.pause) begin
                            state_q     <= StPause;
                            remaining_q <= period_q - count_q;
                        end else begin
                            count_q     <= count_q + WIDTH'(1);
                            remaining_q <= period_q - count_q - WIDTH'(1);
                        end
                    end
                    StPause: begin
                        if (!bus.pause) begin
                            state_q <= StRun;
                        end
                    end
                    default: begin
                        if (bus.start) begin
                            state_q     <= StRun;
                            count_q     <= '0;
                            mode_q      <= bus.oneshot;
                            busy_q      <= 1'b1;
                            done_q      <= 1'b0;
                            remaining_q <= period_nxt;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.tick      = tick_q;
    assign bus.clkout    = clkout_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.remaining = remaining_q;

endmodule

// File: tb/tb_timebase_controller.sv
// Scoreboard bench for timebase_controller: directed scenarios then random stimulus,
// each cycle's expected outputs queued by the stimulus side and checked by a monitor.
module tb_timebase_controller;

    localparam int unsigned W   = 32;
    localparam int unsigned DEF = 25000000;

    logic clk = 1'b0;
    logic reset;

    timebase_controller_if #(.WIDTH(W)) bus ();

    timebase_controller #(
        .WIDTH         (W),
        .DEFAULT_PERIOD(DEF)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          tick;
        bit          clkout;
        bit          busy;
        bit          done;
        logic [31:0] rem;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: a counting session is "active" (maybe frozen) or "finished";
    // elapsed cycles in the current period drive tick and remaining.
    bit    m_active, m_frozen, m_finished, m_single, m_wave, m_tick;
    longint m_cnt, m_per;

    task automatic model_reset();
        m_active = 0; m_frozen = 0; m_finished = 0; m_single = 0;
        m_wave = 1; m_tick = 0; m_cnt = 0; m_per = DEF;
    endtask

    task automatic model_step(input bit we, input logic [31:0] per, input bit st,
                              input bit sp, input bit pa, input bit os);
        bit quiet;
        quiet  = !m_active;
        m_tick = 0;
        if (quiet && we && per != 0) m_per = per;
        if (sp) begin
            m_active = 0; m_frozen = 0; m_finished = 0; m_cnt = 0;
        end else if (m_active && !m_frozen) begin
            if (m_cnt + 1 == m_per) begin
                m_tick = 1;
                m_wave = !m_wave;
                m_cnt  = 0;
                if (m_single) begin
                    m_active = 0; m_finished = 1;
                end else begin
                    m_frozen = pa;
                end
            end else if (pa) begin
                m_frozen = 1;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end else if (m_active) begin
            if (!pa) m_frozen = 0;
        end else if (st) begin
            m_active = 1; m_frozen = 0; m_finished = 0; m_cnt = 0; m_single = os;
        end
    endtask

    task automatic push_expect();
        exp_t e;
        e.tick   = m_tick;
        e.clkout = m_wave;
        e.busy   = m_active;
        e.done   = m_finished;
        e.rem    = m_active ? 32'(m_per - m_cnt) : 32'd0;
        exp_q.push_back(e);
    endtask

    task automatic step(input bit rst_v, input bit we, input logic [31:0] per, input bit st,
                        input bit sp, input bit pa, input bit os);
        @(negedge clk);
        reset          = rst_v;
        bus.cfg_we     = we;
        bus.cfg_period = per;
        bus.start      = st;
        bus.stop       = sp;
        bus.pause      = pa;
        bus.oneshot    = os;
        if (!rst_v) model_reset();
        else model_step(we, per, st, sp, pa, os);
        push_expect();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cfg(input logic [31:0] per);
        step(1, 1, per, 0, 0, 0, 0);
    endtask

    task automatic go(input bit os);
        step(1, 0, 0, 1, 0, 0, os);
    endtask

    task automatic halt();
        step(1, 0, 0, 0, 1, 0, 0);
    endtask

    // Reset dropped between edges: outputs must follow without waiting for clk.
    task automatic async_reset();
        @(posedge clk);
        #3;
        model_reset();
        push_expect();
        reset = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs settle just after a clock edge or an asynchronous reset.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge reset);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("tick", 32'(bus.tick), 32'(e.tick));
                check("clkout", 32'(bus.clkout), 32'(e.clkout));
                check("busy", 32'(bus.busy), 32'(e.busy));
                check("done", 32'(bus.done), 32'(e.done));
                check("remaining", bus.remaining, e.rem);
            end
        end
    end

    initial begin
        bit          we, st, sp, pa, os;
        logic [31:0] per;
        reset = 1'b0;
        bus.cfg_we = 0; bus.cfg_period = '0; bus.start = 0;
        bus.stop = 0; bus.pause = 0; bus.oneshot = 0;
        model_reset();

        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Periodic, period 4.
        cfg(4); go(0); run(13); halt();

        // One-shot, period 3, then restart from DONE.
        cfg(3); go(1); run(6); go(1); run(4);

        // Stop beats start; writes in RUN and zero writes ignored.
        cfg(4); go(0); run(2); step(1, 0, 0, 1, 1, 0, 0);
        go(0); run(1); step(1, 1, 9, 0, 0, 0, 0); run(2); halt();
        step(1, 1, 0, 0, 0, 0, 0); go(0); run(5); halt();

        // Pause at count 2 for 10 cycles, period 5.
        cfg(5); go(0); run(2);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 1, 0);
        run(5);
        // Pause coinciding with expiry.
        run(1); step(1, 0, 0, 0, 0, 1, 0); step(1, 0, 0, 0, 0, 1, 0); run(3); halt();

        // Period 1: tick every cycle, then stop on an expiry cycle.
        cfg(1); go(0); run(4); halt(); run(2);

        // Asynchronous reset at count 2 restores the default period.
        cfg(4); go(0); run(2); async_reset();
        step(0, 0, 0, 0, 0, 0, 0);
        go(0); run(2); halt();

        pa = 0;
        for (int i = 0; i < 3000; i++) begin
            we  = ($urandom_range(0, 3) == 0);
            per = $urandom_range(0, 6);
            st  = ($urandom_range(0, 7) == 0);
            sp  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 9) == 0) pa = !pa;
            os  = 1'($urandom_range(0, 1));
            step(1, we, per, st, sp, pa, os);
        end
        run(1);

        @(posedge clk);
        #3;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
